// File: rtl/pipemem_ctrl.sv
// pipemem_ctrl: MEM-stage req/ack data-memory controller with stall, timeout abort and MEM/WB register
module pipemem_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    input  logic        d_ack,
    output logic        mstall,
    output logic        d_err,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic acc, abort;
    assign acc     = mm2reg | mwmem;
    assign abort   = (state == WAIT) & acc & ~d_ack & (cnt == CW'(TIMEOUT));
    assign d_req   = clrn & acc & ~abort;
    assign d_we    = mwmem;
    assign d_addr  = {malu[31:2], 2'b00};
    assign d_wdata = mb;
    assign mstall  = d_req & ~d_ack;
    // WAIT leaves on ack, abort or a vanished request; otherwise it keeps counting
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        if (state == IDLE) begin
            next_state = mstall ? WAIT : IDLE;
            cnt_next   = mstall ? CW'(1) : '0;
        end else begin
            next_state = mstall ? WAIT : IDLE;
            cnt_next   = mstall ? cnt + 1'b1 : '0;
        end
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            d_err  <= 1'b0;
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            d_err <= d_err | abort;
            if (mstall || abort) begin
                wwreg  <= 1'b0;
                wm2reg <= 1'b0;
            end else begin
                wwreg  <= mwreg;
                wm2reg <= mm2reg;
                walu   <= malu;
                wrn    <= mrn;
            end
            // a combined load+store counts as a store, so only pure loads capture read data
            if (d_req && d_ack && mm2reg && !mwmem)
                wmo <= d_rdata;
        end
    end
endmodule

// File: doc/pipemem_ctrl.md
Name: pipemem_ctrl

Overview:
- MEM-stage controller of the 5-stage pipelined CPU. It consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn) and drives a req/ack data-memory port for loads and stores.
- It stalls the front of the pipeline while an access is outstanding and contains the MEM/WB pipeline register that feeds write-back.
- Accesses that never complete are aborted by a bounded timeout, with a sticky error flag.

Parameters:
- TIMEOUT, 16, maximum wait cycles after the first request cycle before abort; legal range 1..255.
- CW, 8, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- mwreg  in  1  EX/MEM register-write enable.
- mm2reg  in  1  EX/MEM load (memory-to-register) flag.
- mwmem  in  1  EX/MEM store flag.
- malu  in  32  EX/MEM ALU result; the memory byte address for loads and stores.
- mb  in  32  EX/MEM store data.
- mrn  in  5  EX/MEM destination register number.
- d_req  out  1  data-memory request.
- d_we  out  1  data-memory write enable; valid while d_req=1.
- d_addr  out  32  word address {malu[31:2],2'b00}.
- d_wdata  out  32  store data (= mb).
- d_rdata  in  32  load data; sampled only when d_ack=1.
- d_ack  in  1  completion; meaningful only while d_req=1.
- mstall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- d_err  out  1  sticky timeout flag.
- wwreg  out  1  MEM/WB register-write enable.
- wm2reg  out  1  MEM/WB load flag.
- wmo  out  32  MEM/WB memory data.
- walu  out  32  MEM/WB ALU result.
- wrn  out  5  MEM/WB destination register number.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, counter=0.
  - d_err, wwreg, wm2reg = 0; wmo, walu = 0; wrn = 0.
  - d_req forced 0 while clrn=0.
- Access definition: acc = mm2reg | mwmem. If both are set, treat it as a store (d_we=1); wm2reg still follows mm2reg.
- States:
  - IDLE: no abort is pending.
  - WAIT: a request has been outstanding for at least one cycle.
- Combinational bus outputs:
  - d_req = acc & ~abort.
  - d_we = mwmem.
  - d_addr and d_wdata are driven from malu and mb in every state.
  - A zero-wait memory (d_ack in the same cycle as d_req) completes with no stall.
- Stall: mstall = d_req & ~d_ack. EX/MEM holds its contents while mstall=1, so the inputs stay stable throughout the wait.
- Transitions:
  - IDLE -> WAIT when d_req & ~d_ack; counter <= 1.
  - WAIT -> IDLE on d_ack; counter <= 0.
  - WAIT, no ack, counter < TIMEOUT: counter increments.
  - WAIT, no ack, counter == TIMEOUT: abort asserted combinationally for that cycle. Effects of abort:
    - d_req=0 and mstall=0;
    - MEM/WB receives a bubble;
    - d_err <= 1;
    - state <= IDLE, counter <= 0.
  - The aborting instruction then leaves EX/MEM normally at the next edge.
- MEM/WB update at each rising edge:
  - mstall=1 or abort: wwreg <= 0, wm2reg <= 0; wmo, walu, wrn hold.
  - Otherwise: wwreg <= mwreg, wm2reg <= mm2reg, walu <= malu, wrn <= mrn.
  - wmo <= d_rdata when the access is a load completing with d_ack=1; otherwise wmo holds.
- d_err is cleared only by reset.
- A d_ack arriving while d_req=0 is ignored.
- Ack and timeout in the same cycle: ack wins. The access completes normally and d_err is unchanged.
- Reset in the middle of an access drops the request immediately; no partial write-back occurs.
- No misalignment check: malu[1:0] is ignored.

Test Plan:
- Reset: assert clrn=0 mid-stream with random inputs -> all outputs 0, d_req=0; after release with mwreg=1, malu=32'h10, mrn=5, no access -> next edge wwreg=1, walu=32'h10, wrn=5, mstall never asserted.
- Zero-wait load: mm2reg=1, mwreg=1, malu=32'h104, mrn=8, d_ack=1 in the same cycle, d_rdata=32'hDEADBEEF -> d_req=1, d_we=0, d_addr=32'h104, mstall=0; next edge wmo=32'hDEADBEEF, wm2reg=1, wwreg=1, wrn=8.
- Wait-state store: mwmem=1, malu=32'h203, mb=32'hCAFE0001, ack after 3 cycles -> d_addr=32'h200, d_we=1, d_wdata=32'hCAFE0001; mstall=1 for exactly 3 cycles; wwreg=0 on those 3 edges; state returns to IDLE.
- Timeout: TIMEOUT=4, load with d_ack held 0 -> mstall=1 for 4 cycles, abort in the 5th cycle; d_err=1 thereafter, wwreg=0 for that instruction, next non-memory instruction passes through normally.
- Ack at the timeout cycle: ack arrives exactly in the abort cycle -> normal completion, d_err stays 0, wmo captured.
- Reset during WAIT: pull clrn low 2 cycles into a stalled load -> d_req, mstall and d_err drop immediately; counter=0; wwreg=0.
